uart_rx_fifo: RTL

Receive-side buffer for the debug console UART. It accepts bytes from the UART receiver's valid/ready output and holds them in a first-word-fall-through queue for the console consumer, such as the MMIO register block or the debug shell. A serial line cannot be stalled, so the block always accepts input. When the queue is full it drops the incoming byte and records the loss instead of applying backpressure. It also reports the fill level and raises a watermark interrupt.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data/counter widths, 8N1 framing constants and a saturating counter helper.
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH  = 8;
  localparam int DROP_COUNT_WIDTH = 8;

  // 8N1 framing: start bit low, eight data bits LSB first, one stop bit high.
  localparam logic UART_START_BIT      = 1'b0;
  localparam logic UART_STOP_BIT       = 1'b1;
  localparam int   UART_NUM_DATA_BITS  = 8;
  localparam int   UART_NUM_STOP_BITS  = 1;
  localparam int   UART_FRAME_BITS     = 1 + UART_NUM_DATA_BITS + UART_NUM_STOP_BITS;

  typedef logic [DROP_COUNT_WIDTH-1:0] drop_count_t;

  function automatic drop_count_t sat_inc(input drop_count_t value);
    return (&value) ? value : value + drop_count_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// Receive FIFO for the debug console UART: never stalls the receiver, drops and counts bytes when
// full, first-word-fall-through output, registered fill level and watermark interrupt.
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int WATERMARK  = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  input  logic                    i_flush,
  input  logic                    i_clear_overflow,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_overflow,
  output logic [DROP_COUNT_WIDTH-1:0] o_drop_count,
  output logic                    o_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((WATERMARK < 1) || (WATERMARK > DEPTH)) begin : g_bad_watermark
      $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic              ready;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     level;
  logic [PW-1:0]     level_next;
  logic              overflow;
  drop_count_t       drop_count;
  logic              irq;

  logic              push;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              pop_ok;
  logic              drop;

  // Flush wins over everything except the loss tracking, which it leaves alone.
  always_comb begin
    push       = i_valid & ready;
    pop        = (level != '0) & i_ready;
    full       = (level == PW'(DEPTH));
    push_ok    = push & (~full | pop) & ~i_flush;
    pop_ok     = pop & ~i_flush;
    drop       = push & full & ~pop & ~i_flush;
    level_next = level;
    if (i_flush) begin
      level_next = '0;
    end else begin
      level_next = level + PW'(push_ok) - PW'(pop_ok);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      irq    <= 1'b0;
    end else begin
      ready <= 1'b1;
      level <= level_next;
      irq   <= (level_next >= PW'(WATERMARK));
      if (i_flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop_ok) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set and the count at one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= i_clear_overflow ? drop_count_t'(1) : sat_inc(drop_count);
    end else if (i_clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= i_data;
    end
  end

  assign o_ready      = ready;
  assign o_data       = mem[rd_ptr[AW-1:0]];
  assign o_valid      = (level != '0);
  assign o_level      = level;
  assign o_overflow   = overflow;
  assign o_drop_count = drop_count;
  assign o_irq        = irq;

endmodule

`default_nettype wire
